imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter INST_MEMORY_SIZE, default 16384, meaning instruction memory size in bytes.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default $clog2(INST_MEMORY_SIZE), meaning the byte-address width of the programming port.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum clk cycles allowed between received bytes during a load.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port load_req, input, 1 bit: one-cycle request to start a load.
REQ-007 The block SHALL have port rx_data, input, 8 bits: received byte.
REQ-008 The block SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_data; the source has no backpressure.
REQ-009 The block SHALL have port write_addr, output, ADDR_WIDTH bits: byte address to the instruction-memory programming port, always word-aligned.
REQ-010 The block SHALL have port write_data, output, 32 bits: word to the programming port.
REQ-011 The block SHALL have port w_en, output, 1 bit: programming-port write enable.
REQ-012 The block SHALL have port cpu_hold, output, 1 bit: holds the core in reset while high.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a load is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: high after a successful load, until the next load_req.
REQ-015 The block SHALL have port error, output, 1 bit: high after a failed load, until the next load_req.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, LEN, DATA, DONE and ERR.
REQ-017 From IDLE, DONE or ERR, load_req SHALL move the FSM to LEN, clear done, error, the byte counter, the word index and the timeout counter, and assert cpu_hold and busy from the next cycle.
REQ-018 load_req in LEN or DATA SHALL be ignored.
REQ-019 rx_valid in IDLE, DONE or ERR SHALL be ignored.
REQ-020 In LEN, four accepted bytes SHALL form the word count N, little-endian: the first byte goes to N[7:0].
REQ-021 After the fourth LEN byte, N=0 SHALL go to DONE; N > INST_MEMORY_SIZE/4 SHALL go to ERR; otherwise the FSM SHALL go to DATA.
REQ-022 In DATA, the bytes SHALL be assembled little-endian into a 32-bit word.
REQ-023 On the cycle after the fourth byte of word k is accepted, the block SHALL assert w_en for exactly one cycle, with write_addr = 4*k and write_data = the assembled word.
REQ-024 k SHALL start at 0 and increment by one after each write.
REQ-025 After the write of word k = N-1, the FSM SHALL enter DONE on the following cycle.
REQ-026 A byte arriving in the same cycle that w_en is asserted SHALL be accepted into the next word without loss.
REQ-027 In LEN and DATA, the timeout counter SHALL clear on every rx_valid and increment on every other cycle.
REQ-028 When the timeout counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to ERR, and no partial word SHALL be written.
REQ-029 In DONE, cpu_hold SHALL be 0, busy SHALL be 0 and done SHALL be 1.
REQ-030 In ERR, cpu_hold SHALL remain 1, busy SHALL be 0 and error SHALL be 1; a corrupt image never runs.
REQ-031 w_en SHALL never be asserted outside DATA or the exit cycle of DATA.
REQ-032 write_addr and write_data SHALL hold their last values while w_en is low.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 On rst, the FSM SHALL enter IDLE asynchronously, with w_en=0, write_addr=0, write_data=0, cpu_hold=0, busy=0, done=0, error=0, and all counters 0.
REQ-035 rst asserted mid-load SHALL abort the load immediately; writes already issued remain in memory, and no further w_en SHALL occur.
REQ-036 The block SHALL leave IDLE only on load_req after rst is deasserted.

Structure
REQ-037 The FSM state encoding and the header byte count (4) SHALL be defined in a shared package, loader_pkg.
REQ-038 A sub-module byte_to_word SHALL hold the byte counter and the little-endian shift/assemble register, and SHALL output word and word_valid; it is used for both the header and the data.

Verification
REQ-039 The bench SHALL cover: load_req; bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 -> writes (addr 0, 0x00000013) then (addr 4, 0x0000006F), then done=1 and cpu_hold=0.
REQ-040 The bench SHALL cover: header 00 00 00 00 -> DONE directly, with zero w_en pulses.
REQ-041 The bench SHALL cover: header 01 10 00 00 (N=4097, over capacity for 16384 bytes) -> ERR, error=1, cpu_hold=1, no w_en.
REQ-042 The bench SHALL cover: N=1, then 2 data bytes, then silence for TIMEOUT_CYCLES -> ERR, with no write.
REQ-043 The bench SHALL cover: back-to-back rx_valid on every cycle for N=3 -> three w_en pulses at addresses 0, 4 and 8, with no byte lost.
REQ-044 The bench SHALL cover: rst asserted after the first of two words -> immediate IDLE with all outputs 0; a following load_req with N=1 and word 0xDEADBEEF -> a single write at addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// the number of bytes that make up one little-endian word / length header.
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_e;

   localparam int HDR_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler shared by the length header and the
// data payload; word/word_valid are presented in the cycle of the last byte.
module byte_to_word
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  rx_byte,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] shreg_q, shreg_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         shreg_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

   // Bytes shift in from the top so the first byte ends up in bits [7:0].
   always_comb begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (clr) begin
         cnt_d   = '0;
         shreg_d = '0;
      end else if (byte_valid) begin
         cnt_d   = cnt_q + 2'd1;
         shreg_d = {rx_byte, shreg_q[23:8]};
      end
   end

   assign word       = {rx_byte, shreg_q};
   assign word_valid = byte_valid && !clr && (cnt_q == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory, holding the
// core in reset until the whole image has been written successfully.
module imem_loader
   import loader_pkg::*;
#(
   parameter int INST_MEMORY_SIZE = 16384,
   parameter int ADDR_WIDTH       = $clog2(INST_MEMORY_SIZE),
   parameter int TIMEOUT_CYCLES   = 1000000
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_req,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [31:0]           write_data,
   output logic                  w_en,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int          KW        = ADDR_WIDTH - 2;
   localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] MAX_WORDS = 32'(INST_MEMORY_SIZE / 4);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e          state_q, state_d;
   logic [31:0]     n_q, n_d;
   logic [KW-1:0]   k_q, k_d;
   logic [TW-1:0]   to_q, to_d;

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           data_q, data_d;
   logic                  w_en_q, w_en_d;
   logic                  hold_q, hold_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic        clr;
   logic        rx_acc;
   logic [31:0] word;
   logic        word_valid;

   assign rx_acc = rx_valid && ((state_q == S_LEN) || (state_q == S_DATA));

   byte_to_word u_b2w (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .byte_valid (rx_acc),
      .rx_byte    (rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         k_q     <= '0;
         to_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         w_en_q  <= 1'b0;
         hold_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         k_q     <= k_d;
         to_q    <= to_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         w_en_q  <= w_en_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      k_d     = k_q;
      to_d    = to_q;
      clr     = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (load_req) begin
               state_d = S_LEN;
               clr     = 1'b1;
               n_d     = '0;
               k_d     = '0;
               to_d    = '0;
            end
         end
         S_LEN: begin
            if (rx_valid) begin
               to_d = '0;
               if (word_valid) begin
                  n_d = word;
                  if (word == 32'd0)          state_d = S_DONE;
                  else if (word > MAX_WORDS)  state_d = S_ERR;
                  else                        state_d = S_DATA;
               end
            end else if (to_q == TO_LAST) begin
               state_d = S_ERR;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               to_d = '0;
               if (word_valid) begin
                  k_d = k_q + 1'b1;
                  // The last write lands on the same edge the FSM leaves DATA.
                  if (32'(k_q) == (n_q - 32'd1)) state_d = S_DONE;
               end
            end else if (to_q == TO_LAST) begin
               state_d = S_ERR;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      w_en_d = (state_q == S_DATA) && word_valid;
      addr_d = w_en_d ? {k_q, 2'b00} : addr_q;
      data_d = w_en_d ? word : data_q;
      hold_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_ERR);
      busy_d = (state_d == S_LEN) || (state_d == S_DATA);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

   assign write_addr = addr_q;
   assign write_data = data_q;
   assign w_en       = w_en_q;
   assign cpu_hold   = hold_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = err_q;

endmodule
